// File: rtl/mac_array_accelerator_if.sv
// mac_array_accelerator_if
//   Groups the operand, group-control and result handshake signals of
//   mac_array_accelerator.
//   slave  : the accelerator side (consumes beats, produces results).
//   master : the producer/consumer side (drives beats, accepts results).
//   Signals:
//     in_valid / in_ready        beat handshake
//     multiplier_input           NUM_LANES packed signed operands
//     multiplicand_input         NUM_LANES packed signed operands
//     lane_mask                  per-lane enable, sampled with each beat
//     num_passes                 beats per group, sampled on first beat
//     sat_enable                 clamp result, sampled on last beat
//     out_valid / out_ready      result handshake
//     out_data / out_overflow    signed result and range flag
//     busy                       group or result in flight
interface mac_array_accelerator_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int OUT_WIDTH   = 32,
   parameter int MAX_PASSES  = 16,
   parameter int PASS_WIDTH  = $clog2(MAX_PASSES + 1)
) ();
   localparam int NUM_LANES = KERNEL_SIZE * KERNEL_SIZE;

   logic                            in_valid;
   logic                            in_ready;
   logic [NUM_LANES*DATA_WIDTH-1:0] multiplier_input;
   logic [NUM_LANES*DATA_WIDTH-1:0] multiplicand_input;
   logic [NUM_LANES-1:0]            lane_mask;
   logic [PASS_WIDTH-1:0]           num_passes;
   logic                            sat_enable;
   logic                            out_valid;
   logic                            out_ready;
   logic [OUT_WIDTH-1:0]            out_data;
   logic                            out_overflow;
   logic                            busy;

   modport slave (
      input  in_valid, multiplier_input, multiplicand_input, lane_mask,
             num_passes, sat_enable, out_ready,
      output in_ready, out_valid, out_data, out_overflow, busy
   );

   modport master (
      output in_valid, multiplier_input, multiplicand_input, lane_mask,
             num_passes, sat_enable, out_ready,
      input  in_ready, out_valid, out_data, out_overflow, busy
   );
endinterface

// File: rtl/mac_array_accelerator.sv
// mac_array_accelerator
//   NUM_LANES signed multiplier lanes (S1), a registered adder tree (S2) and
//   a multi-pass accumulator (S3) that sums num_passes beats into a single
//   result. The result is presented on a valid/ready output with optional
//   saturation; a held result (out_valid & ~out_ready) freezes the pipeline.
//   Ports:
//     Clk  - rising-edge clock
//     Rst  - asynchronous active-low reset
//     bus  - mac_array_accelerator_if.slave (operands, control, result)
module mac_array_accelerator #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int ACC_WIDTH   = 48,
   parameter int OUT_WIDTH   = 32,
   parameter int MAX_PASSES  = 16,
   parameter int PASS_WIDTH  = $clog2(MAX_PASSES + 1)
) (
   input  logic                    Clk,
   input  logic                    Rst,
   mac_array_accelerator_if.slave  bus
);
   localparam int NUM_LANES  = KERNEL_SIZE * KERNEL_SIZE;
   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   // Zero requested passes means one; anything beyond MAX_PASSES is capped.
   function automatic logic [PASS_WIDTH-1:0] clamp_passes(input logic [PASS_WIDTH-1:0] np);
      if (np == PASS_WIDTH'(0)) begin
         return PASS_WIDTH'(1);
      end else if (np > PASS_WIDTH'(MAX_PASSES)) begin
         return PASS_WIDTH'(MAX_PASSES);
      end else begin
         return np;
      end
   endfunction

   logic                          stall_s;
   logic                          accept_s;
   logic [PASS_WIDTH-1:0]         eff_len_s;
   logic                          first_tag_s;
   logic                          last_tag_s;
   logic [PASS_WIDTH-1:0]         pass_cnt_r;
   logic [PASS_WIDTH-1:0]         pass_len_r;

   logic signed [PROD_WIDTH-1:0]  prod_s [NUM_LANES];
   logic signed [PROD_WIDTH-1:0]  s1_prod_r [NUM_LANES];
   logic                          s1_valid_r, s1_first_r, s1_last_r, s1_sat_r;

   logic signed [ACC_WIDTH-1:0]   lane_sum_s;
   logic signed [ACC_WIDTH-1:0]   s2_sum_r;
   logic                          s2_valid_r, s2_first_r, s2_last_r, s2_sat_r;

   logic signed [ACC_WIDTH-1:0]   acc_r;
   logic signed [ACC_WIDTH-1:0]   acc_next_s;
   logic [OUT_WIDTH-1:0]          out_next_s;
   logic                          ovf_s;
   logic                          out_valid_r;
   logic [OUT_WIDTH-1:0]          out_data_r;
   logic                          out_ovf_r;

   assign stall_s  = out_valid_r & ~bus.out_ready;
   assign accept_s = bus.in_valid & ~stall_s;

   assign bus.in_ready     = ~stall_s;
   assign bus.out_valid    = out_valid_r;
   assign bus.out_data     = out_data_r;
   assign bus.out_overflow = out_ovf_r;
   assign bus.busy         = s1_valid_r | s2_valid_r | (pass_cnt_r != PASS_WIDTH'(0)) | out_valid_r;

   // Tag the incoming beat as first/last of its group.
   always_comb begin
      eff_len_s   = clamp_passes(bus.num_passes);
      first_tag_s = (pass_cnt_r == PASS_WIDTH'(0));
      if (first_tag_s) begin
         last_tag_s = (eff_len_s == PASS_WIDTH'(1));
      end else begin
         last_tag_s = (pass_cnt_r == (pass_len_r - PASS_WIDTH'(1)));
      end
   end

   // Pass counter and group length latched on the first beat.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pass_cnt_r <= PASS_WIDTH'(0);
         pass_len_r <= PASS_WIDTH'(1);
      end else if (accept_s) begin
         if (first_tag_s) begin
            pass_len_r <= eff_len_s;
         end
         if (last_tag_s) begin
            pass_cnt_r <= PASS_WIDTH'(0);
         end else begin
            pass_cnt_r <= pass_cnt_r + PASS_WIDTH'(1);
         end
      end
   end

   // Per-lane signed products; masked lanes contribute zero.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (bus.lane_mask[i]) begin
            prod_s[i] = $signed(bus.multiplier_input[i*DATA_WIDTH +: DATA_WIDTH]) *
                        $signed(bus.multiplicand_input[i*DATA_WIDTH +: DATA_WIDTH]);
         end else begin
            prod_s[i] = '0;
         end
      end
   end

   // S1: product registers and beat tags.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s1_valid_r <= 1'b0;
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_sat_r   <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            s1_prod_r[i] <= '0;
         end
      end else if (!stall_s) begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_first_r <= first_tag_s;
            s1_last_r  <= last_tag_s;
            s1_sat_r   <= bus.sat_enable;
            for (int i = 0; i < NUM_LANES; i++) begin
               s1_prod_r[i] <= prod_s[i];
            end
         end
      end
   end

   // Sign-extended adder tree over all lanes.
   always_comb begin
      lane_sum_s = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_sum_s = lane_sum_s +
            {{(ACC_WIDTH-PROD_WIDTH){s1_prod_r[i][PROD_WIDTH-1]}}, s1_prod_r[i]};
      end
   end

   // S2: lane sum register and tags.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s2_valid_r <= 1'b0;
         s2_first_r <= 1'b0;
         s2_last_r  <= 1'b0;
         s2_sat_r   <= 1'b0;
         s2_sum_r   <= '0;
      end else if (!stall_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_first_r <= s1_first_r;
            s2_last_r  <= s1_last_r;
            s2_sat_r   <= s1_sat_r;
            s2_sum_r   <= lane_sum_s;
         end
      end
   end

   // Next accumulator value (wrapping) and its saturated/wrapped output view.
   always_comb begin
      if (s2_first_r) begin
         acc_next_s = s2_sum_r;
      end else begin
         acc_next_s = acc_r + s2_sum_r;
      end
      if (acc_next_s > OUT_MAX) begin
         ovf_s      = 1'b1;
         out_next_s = s2_sat_r ? OUT_MAX[OUT_WIDTH-1:0] : acc_next_s[OUT_WIDTH-1:0];
      end else if (acc_next_s < OUT_MIN) begin
         ovf_s      = 1'b1;
         out_next_s = s2_sat_r ? OUT_MIN[OUT_WIDTH-1:0] : acc_next_s[OUT_WIDTH-1:0];
      end else begin
         ovf_s      = 1'b0;
         out_next_s = acc_next_s[OUT_WIDTH-1:0];
      end
   end

   // S3 accumulator and output register; the last beat loads the result.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         acc_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_ovf_r   <= 1'b0;
      end else if (!stall_s) begin
         if (s2_valid_r) begin
            acc_r <= acc_next_s;
         end
         // Not stalled means any held result is being consumed this cycle.
         out_valid_r <= s2_valid_r & s2_last_r;
         if (s2_valid_r & s2_last_r) begin
            out_data_r <= out_next_s;
            out_ovf_r  <= ovf_s;
         end
      end
   end
endmodule

// File: tb/tb_mac_array_accelerator.sv
// tb_mac_array_accelerator
//   Directed bench for mac_array_accelerator with hand-computed expectations.
module tb_mac_array_accelerator;
   localparam int DW = 16;
   localparam int NL = 9;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   int   checks = 0;
   int   fails  = 0;

   int        got[$];
   int        sent;
   int        first_seen;
   logic      was_stalled;
   logic [31:0] held;

   always #5 Clk = ~Clk;

   mac_array_accelerator_if #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .OUT_WIDTH(32),
                              .MAX_PASSES(16)) bus ();

   mac_array_accelerator #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .ACC_WIDTH(48),
                           .OUT_WIDTH(32), .MAX_PASSES(16)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   // All lanes carry a*b.
   task automatic beat(input int a, input int b, input logic [8:0] mask,
                       input logic [4:0] np, input logic sat);
      bus.in_valid = 1'b1;
      for (int i = 0; i < NL; i++) begin
         bus.multiplier_input[i*DW +: DW]   = DW'(a);
         bus.multiplicand_input[i*DW +: DW] = DW'(b);
      end
      bus.lane_mask  = mask;
      bus.num_passes = np;
      bus.sat_enable = sat;
   endtask

   // Only lane 0 carries a*b, other lanes are zero.
   task automatic lane0_beat(input int a, input int b, input logic [4:0] np);
      beat(0, 0, 9'h1FF, np, 1'b0);
      bus.multiplier_input[0 +: DW]   = DW'(a);
      bus.multiplicand_input[0 +: DW] = DW'(b);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid           = 1'b0;
      bus.out_ready          = 1'b1;
      bus.multiplier_input   = '0;
      bus.multiplicand_input = '0;
      bus.lane_mask          = '0;
      bus.num_passes         = '0;
      bus.sat_enable         = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_data", $signed(bus.out_data), 0);
      check("rst_overflow", bus.out_overflow, 0);
      Rst = 1'b1;
      step();

      // Single pass: 9 lanes of 2*3 = 54, result three edges after the beat cycle.
      beat(2, 3, 9'h1FF, 5'd1, 1'b0);
      step();
      idle();
      check("single_lat1", bus.out_valid, 0);
      check("single_busy", bus.busy, 1);
      step();
      check("single_lat2", bus.out_valid, 0);
      step();
      check("single_valid", bus.out_valid, 1);
      check("single_data", $signed(bus.out_data), 54);
      check("single_ovf", bus.out_overflow, 0);
      step();
      check("single_once", bus.out_valid, 0);
      check("single_idle", bus.busy, 0);

      // Three-pass group (162) immediately followed by a one-pass group (-35).
      beat(2, 3, 9'h1FF, 5'd3, 1'b0);
      step();
      check("multi_no_early1", bus.out_valid, 0);
      beat(2, 3, 9'h1FF, 5'd3, 1'b0);
      step();
      check("multi_no_early2", bus.out_valid, 0);
      beat(2, 3, 9'h1FF, 5'd3, 1'b0);
      step();
      check("multi_no_early3", bus.out_valid, 0);
      lane0_beat(-7, 5, 5'd1);
      step();
      idle();
      check("multi_no_early4", bus.out_valid, 0);
      step();
      check("multi_valid", bus.out_valid, 1);
      check("multi_data", $signed(bus.out_data), 162);
      step();
      check("next_valid", bus.out_valid, 1);
      check("next_data", $signed(bus.out_data), -35);
      step();
      check("next_once", bus.out_valid, 0);

      // Mask: only lanes 0 and 2 contribute -> 12.
      beat(2, 3, 9'b000000101, 5'd1, 1'b0);
      step();
      idle();
      step();
      step();
      check("mask_valid", bus.out_valid, 1);
      check("mask_data", $signed(bus.out_data), 12);
      step();

      // Saturation: 9 * 2^30 exceeds the 32-bit range.
      beat(-32768, -32768, 9'h1FF, 5'd1, 1'b1);
      step();
      beat(-32768, -32768, 9'h1FF, 5'd1, 1'b0);
      step();
      idle();
      step();
      check("sat_data", $signed(bus.out_data), 2147483647);
      check("sat_ovf", bus.out_overflow, 1);
      step();
      check("wrap_data", $signed(bus.out_data), 1073741824);
      check("wrap_ovf", bus.out_overflow, 1);
      step();

      // num_passes = 0 behaves as a single pass.
      beat(2, 3, 9'h1FF, 5'd0, 1'b0);
      step();
      idle();
      step();
      step();
      check("np0_valid", bus.out_valid, 1);
      check("np0_data", $signed(bus.out_data), 54);
      step();
      check("np0_once", bus.out_valid, 0);

      // Backpressure: 6 single-pass beats, results 10..60, 5 stalled cycles.
      sent        = 0;
      first_seen  = -1;
      was_stalled = 1'b0;
      held        = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (first_seen < 0 && bus.out_valid) begin
            first_seen = cyc;
         end
         bus.out_ready = !(first_seen >= 0 && cyc < first_seen + 5);
         #1;
         if (bus.out_valid && !bus.out_ready) begin
            check("bp_in_ready", bus.in_ready, 0);
            if (was_stalled) begin
               check("bp_hold", $signed(bus.out_data), $signed(held));
            end
            held        = bus.out_data;
            was_stalled = 1'b1;
         end else begin
            was_stalled = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            got.push_back($signed(bus.out_data));
         end
         if (sent < 6) begin
            lane0_beat(sent + 1, 10, 5'd1);
            if (bus.in_ready) begin
               sent++;
            end
         end else begin
            idle();
         end
         step();
      end
      bus.out_ready = 1'b1;
      check("bp_count", got.size(), 6);
      for (int k = 0; k < got.size() && k < 6; k++) begin
         check("bp_data", got[k], 10 * (k + 1));
      end

      // Reset in the middle of a three-pass group discards the partial sum.
      beat(2, 3, 9'h1FF, 5'd3, 1'b0);
      step();
      step();
      idle();
      Rst = 1'b0;
      #1;
      check("rst_mid_valid", bus.out_valid, 0);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_ready", bus.in_ready, 1);
      @(negedge Clk);
      Rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rst_no_out", bus.out_valid, 0);
      end
      beat(2, 3, 9'h1FF, 5'd1, 1'b0);
      step();
      idle();
      step();
      step();
      check("rst_after_valid", bus.out_valid, 1);
      check("rst_after_data", $signed(bus.out_data), 54);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
